// File: rtl/positaccum_readout_16_pkg.sv
// Shared types and constants for the posit16 (es=2) accumulator readout.
// Serialized accumulator layout, MSB first:
//   {sgn, scale[7:0], fraction[FBITS_ACCUM-1:0], inf, zero}
package positaccum_readout_16_pkg;

  localparam int FBITS_ACCUM                      = 24;
  localparam int SCALE_BITS                       = 8;
  localparam int POSIT_SERIALIZED_WIDTH_ACCUM_ES2 = 1 + SCALE_BITS + FBITS_ACCUM + 2;

  localparam int          POSIT16_ES2_MAXPOS_SCALE = 56;
  localparam logic [15:0] POSIT16_NAR              = 16'h8000;
  localparam logic [14:0] POSIT16_MAG_MAX          = 15'h7FFF;
  localparam logic [14:0] POSIT16_MAG_MIN          = 15'h0001;

  typedef struct packed {
    logic                   sgn;
    logic [SCALE_BITS-1:0]  scale;
    logic [FBITS_ACCUM-1:0] fraction;
    logic                   inf;
    logic                   zero;
  } value_accum_t;

  // S1 -> S2: classified and clamped value, regime run length k and exponent e
  typedef struct packed {
    logic                   sgn;
    logic signed [4:0]      k;
    logic [1:0]             e;
    logic [FBITS_ACCUM-1:0] frac;
    logic                   zero;
    logic                   nar;
    logic                   sat_hi;
    logic                   sat_lo;
  } s1_t;

  // S2 -> S3: assembled magnitude plus rounding bits
  typedef struct packed {
    logic        sgn;
    logic [14:0] mag;
    logic        guard;
    logic        sticky;
    logic        zero;
    logic        nar;
    logic        sat_hi;
    logic        sat_lo;
  } s2_t;

  function automatic value_accum_t unpack_accum(
    input logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] raw
  );
    value_accum_t v;
    v.sgn      = raw[POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1];
    v.scale    = raw[POSIT_SERIALIZED_WIDTH_ACCUM_ES2-2 -: SCALE_BITS];
    v.fraction = raw[FBITS_ACCUM+1:2];
    v.inf      = raw[1];
    v.zero     = raw[0];
    return v;
  endfunction

endpackage

// File: rtl/posit_round_encode_16.sv
// Combinational posit16 es=2 encoder, split into two halves so the caller can
// place a register between them.
//   assemble: k_i, e_i, frac_i           -> asm_mag_o, asm_guard_o, asm_sticky_o
//   round:    rnd_* (mag, rounding bits,
//             sign, specials, saturation) -> posit_o
module posit_round_encode_16
  import positaccum_readout_16_pkg::*;
(
  input  logic signed [4:0]       k_i,
  input  logic [1:0]              e_i,
  input  logic [FBITS_ACCUM-1:0]  frac_i,
  output logic [14:0]             asm_mag_o,
  output logic                    asm_guard_o,
  output logic                    asm_sticky_o,
  input  logic [14:0]             rnd_mag_i,
  input  logic                    rnd_guard_i,
  input  logic                    rnd_sticky_i,
  input  logic                    rnd_sgn_i,
  input  logic                    rnd_zero_i,
  input  logic                    rnd_nar_i,
  input  logic                    rnd_sat_hi_i,
  input  logic                    rnd_sat_lo_i,
  output logic [15:0]             posit_o
);

  logic [4:0]                 k_abs;
  logic [4:0]                 rlen;
  logic [15:0]                regime;
  logic [FBITS_ACCUM+1:0]     body;
  logic [47:0]                field;

  // Regime is built MSB-aligned in 16 bits (k=+14 needs 16 bits), then the
  // exponent/fraction body is shifted in directly behind it.
  always_comb begin
    k_abs = k_i[4] ? (5'd0 - k_i) : k_i;
    if (!k_i[4]) begin
      regime = ~(16'hFFFF >> (k_abs + 5'd1));
      rlen   = k_abs + 5'd2;
    end else begin
      regime = 16'h8000 >> k_abs;
      rlen   = k_abs + 5'd1;
    end
    body         = {e_i, frac_i};
    field        = {regime, 32'd0} | ({body, 22'd0} >> rlen);
    asm_mag_o    = field[47:33];
    asm_guard_o  = field[32];
    asm_sticky_o = |field[31:0];
  end

  logic [15:0] sum;
  logic [14:0] mag;

  // Rounding carry may ripple into the regime; that is still a valid,
  // monotonic posit, so only the extremes need clamping.
  always_comb begin
    sum = {1'b0, rnd_mag_i} + {15'd0, rnd_guard_i & (rnd_sticky_i | rnd_mag_i[0])};
    if (sum[15])              mag = POSIT16_MAG_MAX;
    else if (sum[14:0] == '0) mag = POSIT16_MAG_MIN;
    else                      mag = sum[14:0];
    if (rnd_sat_hi_i) mag = POSIT16_MAG_MAX;
    if (rnd_sat_lo_i) mag = POSIT16_MAG_MIN;
    posit_o = rnd_sgn_i ? (16'd0 - {1'b0, mag}) : {1'b0, mag};
    if (rnd_nar_i)       posit_o = POSIT16_NAR;
    else if (rnd_zero_i) posit_o = 16'h0000;
  end

endmodule

// File: rtl/positaccum_readout_16.sv
// Three-stage readout: ES2 accumulator raw value -> rounded posit16 es=2.
//   clk, rst_n           clock / async active-low reset
//   in_data/valid/ready  serialized accumulator value, handshake
//   out_posit/valid/ready encoded posit16, handshake
// S1 classify/clamp, S2 assemble, S3 round/sign. All stages advance together
// unless the output is held; a held output freezes the whole pipe.
module positaccum_readout_16
  import positaccum_readout_16_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int ES    = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic [NBITS-1:0]                            out_posit,
  output logic                                        out_valid,
  input  logic                                        out_ready
);

  localparam logic signed [7:0] SCALE_MAX = 8'(POSIT16_ES2_MAXPOS_SCALE);
  localparam logic signed [7:0] SCALE_MIN = -SCALE_MAX;

  value_accum_t      acc;
  logic signed [7:0] scale_s;
  logic signed [7:0] clamped;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic              s1_valid_q, s2_valid_q;
  logic              out_valid_q;
  logic [NBITS-1:0]  out_posit_q;
  logic              ready_en_q;
  logic              stall;
  logic [15:0]       posit_c;
  logic [14:0]       asm_mag;
  logic              asm_guard, asm_sticky;

  assign stall    = out_valid_q & ~out_ready;
  // ready_en_q keeps in_ready low until the first clock after reset release
  assign in_ready = ready_en_q & ~stall;

  always_comb begin
    acc        = unpack_accum(in_data);
    scale_s    = $signed(acc.scale);
    s1_d       = '0;
    s1_d.sgn   = acc.sgn;
    s1_d.nar   = acc.inf;
    s1_d.zero  = acc.zero & ~acc.inf;
    s1_d.sat_hi = scale_s > SCALE_MAX;
    s1_d.sat_lo = scale_s < SCALE_MIN;
    if (s1_d.sat_hi)      clamped = SCALE_MAX;
    else if (s1_d.sat_lo) clamped = SCALE_MIN;
    else                  clamped = scale_s;
    s1_d.k    = 5'(clamped >>> ES);
    s1_d.e    = clamped[ES-1:0];
    s1_d.frac = acc.fraction;
  end

  posit_round_encode_16 u_enc (
    .k_i          (s1_q.k),
    .e_i          (s1_q.e),
    .frac_i       (s1_q.frac),
    .asm_mag_o    (asm_mag),
    .asm_guard_o  (asm_guard),
    .asm_sticky_o (asm_sticky),
    .rnd_mag_i    (s2_q.mag),
    .rnd_guard_i  (s2_q.guard),
    .rnd_sticky_i (s2_q.sticky),
    .rnd_sgn_i    (s2_q.sgn),
    .rnd_zero_i   (s2_q.zero),
    .rnd_nar_i    (s2_q.nar),
    .rnd_sat_hi_i (s2_q.sat_hi),
    .rnd_sat_lo_i (s2_q.sat_lo),
    .posit_o      (posit_c)
  );

  always_comb begin
    s2_d        = '0;
    s2_d.sgn    = s1_q.sgn;
    s2_d.mag    = asm_mag;
    s2_d.guard  = asm_guard;
    s2_d.sticky = asm_sticky;
    s2_d.zero   = s1_q.zero;
    s2_d.nar    = s1_q.nar;
    s2_d.sat_hi = s1_q.sat_hi;
    s2_d.sat_lo = s1_q.sat_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_posit_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (!stall) begin
        s1_valid_q  <= in_valid & in_ready;
        s1_q        <= s1_d;
        s2_valid_q  <= s1_valid_q;
        s2_q        <= s2_d;
        out_valid_q <= s2_valid_q;
        out_posit_q <= posit_c;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;

endmodule
